// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache, 4 lines x 4 words.
// Define DCACHE_STATS_EN to build saturating hit/miss counters; otherwise they read as 0.
module dcache (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemReadM,
    input  logic         MemWriteM,
    input  logic         ByteM,
    input  logic [31:0]  ALUOutM,
    input  logic [31:0]  WriteDataM,
    output logic [31:0]  ReadData,
    output logic         dhit,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    typedef enum logic [1:0] {IDLE, WRBACK, FILL, UPDATE} state_t;
    state_t        state_q;
    logic [3:0]    valid_q, dirty_q;
    logic [25:0]   tag_q [4];
    logic [127:0]  data_q [4];
    logic [127:0]  line_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [127:0]  mem_wdata_q;
    logic [1:0]    idx, wsel, lane;
    logic          acc, hit, idle, st_hit;
    logic [31:0]   rd_word, st_word_d;

    assign idx    = ALUOutM[5:4];
    assign wsel   = ALUOutM[3:2];
    assign lane   = ALUOutM[1:0];
    assign acc    = MemReadM | MemWriteM;
    assign hit    = valid_q[idx] && (tag_q[idx] == ALUOutM[31:6]);
    assign idle   = state_q == IDLE;
    assign st_hit = idle && MemWriteM && hit;
    // Word 0 sits in the most significant 32 bits of a line.
    assign rd_word  = data_q[idx][{~wsel, 5'b0} +: 32];
    assign dhit     = idle && (!acc || hit);
    assign ReadData = (idle && MemReadM && !MemWriteM && hit) ? rd_word : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        st_word_d = ByteM ? rd_word : WriteDataM;
        if (ByteM) st_word_d[{~lane, 3'b0} +: 8] = WriteDataM[7:0];
    end

    // Tag/data storage carries no reset; valid_q alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_ack) line_q <= mem_rdata;
        if (state_q == UPDATE) begin
            data_q[idx] <= line_q;
            tag_q[idx]  <= ALUOutM[31:6];
        end else if (st_hit) begin
            data_q[idx][{~wsel, 5'b0} +: 32] <= st_word_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc && !hit) begin
                        mem_req_q <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx, 4'b0};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            state_q    <= FILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {ALUOutM[31:4], 4'b0};
                        end
                    end else if (st_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRBACK: begin
                    if (mem_ack) begin
                        state_q    <= FILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {ALUOutM[31:4], 4'b0};
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state_q   <= UPDATE;
                        mem_req_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    state_q      <= IDLE;
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    logic        missed_q;

    // missed_q keeps the completion of a refilled access from counting as a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q    <= '0;
            miss_q   <= '0;
            missed_q <= 1'b0;
        end else if (idle && acc) begin
            if (!hit) begin
                missed_q <= 1'b1;
                if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            end else begin
                missed_q <= 1'b0;
                if (!missed_q && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: random loads/stores against a flat architectural memory plus a tag-level cache model.
module tb_dcache;
    logic         clk = 1'b0, reset = 1'b0;
    logic         MemReadM = 1'b0, MemWriteM = 1'b0, ByteM = 1'b0, mem_ack = 1'b0;
    logic [31:0]  ALUOutM = '0, WriteDataM = '0, ReadData, mem_addr;
    logic         dhit, mem_req, mem_we;
    logic [127:0] mem_wdata, mem_rdata = '0;
    logic [15:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    dcache dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadData(ReadData), .dhit(dhit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    logic [31:0]  bmem [64];
    logic [31:0]  gold [64];
    logic         m_valid [4];
    logic         m_dirty [4];
    logic [25:0]  m_tag [4];
    logic [127:0] last_wb;
    logic         first_dhit;
    int n_pass = 0, n_chk = 0, m_hits = 0, m_miss = 0, force_lat = -1, last_stall = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] gline(input logic [31:0] a);
        int b;
        b = int'(a[7:4]) * 4;
        return {gold[b], gold[b+1], gold[b+2], gold[b+3]};
    endfunction

    function automatic logic [127:0] bline(input logic [31:0] a);
        int b;
        b = int'(a[7:4]) * 4;
        return {bmem[b], bmem[b+1], bmem[b+2], bmem[b+3]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) gold[i] = bmem[i];
        m_hits = 0;
        m_miss = 0;
    endfunction

    task automatic do_reset();
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Entered at a falling edge; plays the memory side with random ack latency.
    task automatic do_access(input logic rd, input logic wr, input logic bm,
                             input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rdat);
        logic [1:0]  ix;
        logic        miss, wbx, done, busy;
        logic [31:0] vaddr, w;
        int stall, lat, lat_sum, wbs, fills, sh, b;
        ix = a[5:4];
        miss = !(m_valid[ix] && m_tag[ix] == a[31:6]);
        wbx = miss && m_valid[ix] && m_dirty[ix];
        vaddr = {m_tag[ix], ix, 4'b0};
        done = 1'b0; busy = 1'b0; rdat = '0;
        stall = 0; lat = 0; lat_sum = 0; wbs = 0; fills = 0;
        MemReadM = rd; MemWriteM = wr; ByteM = bm; ALUOutM = a; WriteDataM = wd;
        #1;
        first_dhit = dhit;
        chk("dhit_first", dhit, !miss);
        for (int c = 0; c < 60 && !done; c++) begin
            if (dhit) begin
                done = 1'b1;
                rdat = ReadData;
                mem_ack = 1'b0;
            end else begin
                stall++;
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        lat = force_lat >= 0 ? force_lat : $urandom_range(0, 3);
                        lat_sum += lat + 1;
                    end
                    if (lat == 0) begin
                        busy = 1'b0;
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            wbs++;
                            chk("wb_addr", mem_addr, vaddr);
                            chk("wb_data", mem_wdata, gline(vaddr));
                            last_wb = mem_wdata;
                            b = int'(mem_addr[7:4]) * 4;
                            for (int k = 0; k < 4; k++) bmem[b+k] = mem_wdata[32*(3-k) +: 32];
                        end else begin
                            fills++;
                            chk("fill_addr", mem_addr, {a[31:4], 4'b0});
                            mem_rdata = bline(a);
                        end
                    end else begin
                        lat--;
                    end
                end else begin
                    mem_ack = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                #1;
            end
        end
        last_stall = stall;
        chk("done", done, 1'b1);
        chk("req_idle", mem_req, 1'b0);
        chk("fills", fills, miss);
        chk("wbs", wbs, wbx);
        chk("stall", stall, miss ? 2 + lat_sum : 0);
        if (rd && !wr) chk("rdata", rdat, gold[a[7:2]]);
        else chk("st_rdata0", rdat, 32'd0);
        if (miss) begin
            m_valid[ix] = 1'b1;
            m_tag[ix] = a[31:6];
            m_dirty[ix] = 1'b0;
            m_miss++;
        end else begin
            m_hits++;
        end
        if (wr) begin
            w = gold[a[7:2]];
            if (bm) begin
                sh = 24 - 8 * int'(a[1:0]);
                w = (w & ~(32'hFF << sh)) | ({24'd0, wd[7:0]} << sh);
            end else begin
                w = wd;
            end
            gold[a[7:2]] = w;
            m_dirty[ix] = 1'b1;
        end
        @(negedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        chk("hit_cnt", hit_count, 16'(m_hits));
        chk("miss_cnt", miss_count, 16'(m_miss));
`else
        chk("hit_cnt0", hit_count, 16'd0);
        chk("miss_cnt0", miss_count, 16'd0);
`endif
    endtask

    initial begin
        logic [31:0] r, a;
        int op;
        for (int i = 0; i < 64; i++) bmem[i] = $urandom;
        bmem[16] = 32'h11111111; bmem[17] = 32'h22222222;
        bmem[18] = 32'h33333333; bmem[19] = 32'h44444444;
        @(negedge clk);
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 128'd0);
        chk("rst_dhit", dhit, 1'b1);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_hits", hit_count, 16'd0);
        chk("rst_miss", miss_count, 16'd0);
        @(negedge clk);
        do_reset();

        force_lat = 3;
        do_access(1, 0, 0, 32'h40, 32'd0, r);
        chk("ld40", r, 32'h11111111);
        force_lat = -1;
        do_access(0, 1, 1, 32'h45, 32'h000000AB, r);
        chk("sb45_hit", first_dhit, 1'b1);
        do_access(1, 0, 0, 32'h44, 32'd0, r);
        chk("ld44", r, 32'h22AB2222);
        do_access(1, 0, 0, 32'h80, 32'd0, r);
        chk("wb40_word1", last_wb[95:64], 32'h22AB2222);
`ifdef DCACHE_STATS_EN
        chk("seq_hits", hit_count, 16'd2);
        chk("seq_miss", miss_count, 16'd2);
`endif
        force_lat = 0;
        do_access(1, 0, 0, 32'hC0, 32'd0, r);
        chk("miss_penalty", last_stall, 3);
        force_lat = -1;

        do_reset();
        MemReadM = 1'b1; ALUOutM = 32'h40;
        @(negedge clk);
        #1;
        chk("fill_req", mem_req, 1'b1);
        chk("fill_we", mem_we, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_req", mem_req, 1'b0);
        chk("async_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; MemReadM = 1'b0;
        model_reset();
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_dhit", dhit, 1'b1);
        @(negedge clk);
        do_access(1, 0, 0, 32'h40, 32'd0, r);
        chk("reload40_miss", first_dhit, 1'b0);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 2);
            a = {24'd0, 8'($urandom_range(0, 255))};
            if (op == 0) do_access(1, 0, 0, a, $urandom, r);
            else do_access(1'($urandom_range(0, 1)), 1, op == 2, a, $urandom, r);
            if ($urandom_range(0, 3) == 0) begin
                MemReadM = 1'b0; MemWriteM = 1'b0;
                #1;
                chk("idle_dhit", dhit, 1'b1);
                @(negedge clk);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
